// File: rtl/muldiv_unit_pkg.sv
// Shared types for the RV M-extension multiply/divide unit: funct3 op
// encoding, FSM states and the iteration counter width.
package tcore_param;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } muldiv_state_e;

   localparam int MULDIV_XLEN  = 32;
   localparam int MULDIV_CNT_W = $clog2(MULDIV_XLEN);

   // Counter width for an arbitrary XLEN; never narrower than one bit.
   function automatic int muldiv_cnt_w(input int xlen);
      return (xlen > 2) ? $clog2(xlen) : 1;
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Start/busy/valid handshake bundle between the EX stage and muldiv_unit.
interface muldiv_if #(
   parameter int XLEN = tcore_param::MULDIV_XLEN
) ();

   logic            start_i;
   logic [2:0]      op_i;
   logic [XLEN-1:0] a_i;
   logic [XLEN-1:0] b_i;
   logic            kill_i;
   logic            busy_o;
   logic            valid_o;
   logic [XLEN-1:0] result_o;

   modport master (
      output start_i, op_i, a_i, b_i, kill_i,
      input  busy_o, valid_o, result_o
   );

   modport slave (
      input  start_i, op_i, a_i, b_i, kill_i,
      output busy_o, valid_o, result_o
   );

endinterface

// File: rtl/muldiv_unit_iter.sv
// Combinational iteration kernel. One call retires MUL_STEP multiplier bits
// (shift-add into {hi, lo}, lo initially holding the multiplier) and,
// separately, DIV_STEP quotient bits (restoring division on {rem, quo}, quo
// initially holding the dividend). Operands are unsigned magnitudes.
module muldiv_iter #(
   parameter int XLEN     = 32,
   parameter int MUL_STEP = 1,
   parameter int DIV_STEP = 1
) (
   input  logic [2*XLEN-1:0] acc_i,
   input  logic [XLEN-1:0]   opnd_i,
   output logic [2*XLEN-1:0] mul_acc_o,
   output logic [2*XLEN-1:0] div_acc_o
);

   logic [2*XLEN-1:0] m_acc;
   logic [XLEN:0]     m_sum;
   logic [2*XLEN-1:0] d_acc;
   logic [XLEN:0]     d_rem;
   logic              d_bit;

   // Multiply: add multiplicand into the high half when the lsb is set, then shift right.
   always_comb begin
      m_acc = acc_i;
      m_sum = '0;
      for (int i = 0; i < MUL_STEP; i++) begin
         m_sum = {1'b0, m_acc[2*XLEN-1:XLEN]} + (m_acc[0] ? {1'b0, opnd_i} : '0);
         m_acc = {m_sum, m_acc[XLEN-1:1]};
      end
      mul_acc_o = m_acc;
   end

   // Divide: shift next dividend bit into the partial remainder, subtract if it fits.
   always_comb begin
      d_acc = acc_i;
      d_rem = '0;
      d_bit = 1'b0;
      for (int i = 0; i < DIV_STEP; i++) begin
         d_rem = {d_acc[2*XLEN-1:XLEN], d_acc[XLEN-1]};
         d_bit = (d_rem >= {1'b0, opnd_i});
         if (d_bit) d_rem = d_rem - {1'b0, opnd_i};
         d_acc = {d_rem[XLEN-1:0], d_acc[XLEN-2:0], d_bit};
      end
      div_acc_o = d_acc;
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Operands are reduced to magnitudes at issue, iterated unsigned, and the
// sign fix-up happens in FIX. Divide-by-zero and signed overflow bypass the
// iteration and complete one cycle after issue.
// Optional: define MULDIV_RESULT_CACHE_EN to keep the last divide's quotient
// and remainder so a matching DIV/REM pair finishes without iterating.
module muldiv_unit
   import tcore_param::*;
#(
   parameter int XLEN     = MULDIV_XLEN,
   parameter int MUL_STEP = 1,
   parameter int DIV_STEP = 1
) (
   input  logic    clk_i,
   input  logic    rst_i,
   muldiv_if.slave bus
);

   localparam int              CNT_W    = muldiv_cnt_w(XLEN);
   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(XLEN / MUL_STEP - 1);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN / DIV_STEP - 1);
   localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_e     state_q, state_d;
   muldiv_op_e        op_q;
   logic              neg_res_q, neg_rem_q;
   logic [2*XLEN-1:0] acc_q;
   logic [XLEN-1:0]   opnd_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [XLEN-1:0]   res_q;
   logic [XLEN-1:0]   result_q;

   logic              accept;
   logic              hit;
   logic [XLEN-1:0]   hit_res;

   // issue-side decode
   muldiv_op_e        op_in;
   logic              div_in, a_sgn, b_sgn, a_neg, b_neg;
   logic              div_zero, div_ovf, special;
   logic [XLEN-1:0]   abs_a, abs_b, spc_quo, spc_rem, spc_res;

   // fix-up side
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo_f, rem_f, fix_res;
   logic [2*XLEN-1:0] mul_nxt, div_nxt;

   muldiv_iter #(
      .XLEN     (XLEN),
      .MUL_STEP (MUL_STEP),
      .DIV_STEP (DIV_STEP)
   ) u_iter (
      .acc_i     (acc_q),
      .opnd_i    (opnd_q),
      .mul_acc_o (mul_nxt),
      .div_acc_o (div_nxt)
   );

   // Decode the incoming request: signedness, magnitudes and special cases.
   always_comb begin
      op_in    = muldiv_op_e'(bus.op_i);
      div_in   = bus.op_i[2];
      a_sgn    = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
      b_sgn    = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
      a_neg    = a_sgn & bus.a_i[XLEN-1];
      b_neg    = b_sgn & bus.b_i[XLEN-1];
      abs_a    = a_neg ? -bus.a_i : bus.a_i;
      abs_b    = b_neg ? -bus.b_i : bus.b_i;
      div_zero = (bus.b_i == '0);
      div_ovf  = b_sgn & (bus.a_i == MIN_NEG) & (bus.b_i == '1);
      special  = div_in & (div_zero | div_ovf);
      spc_quo  = div_zero ? '1 : bus.a_i;
      spc_rem  = div_zero ? bus.a_i : '0;
      spc_res  = bus.op_i[1] ? spc_rem : spc_quo;
   end

   // Sign correction of the finished magnitude and result-half selection.
   always_comb begin
      prod  = neg_res_q ? -acc_q : acc_q;
      quo_f = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem_f = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      if (op_q[2])
         fix_res = op_q[1] ? rem_f : quo_f;
      else if (op_q == OP_MUL)
         fix_res = prod[XLEN-1:0];
      else
         fix_res = prod[2*XLEN-1:XLEN];
   end

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next state; kill wins over everything except reset.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start_i && !bus.kill_i) begin
               accept  = 1'b1;
               state_d = (special || hit) ? DONE : CALC;
            end
         end
         CALC:    if (cnt_q == '0) state_d = FIX;
         FIX:     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.kill_i) state_d = IDLE;
   end

   // Datapath: latch operands at issue, iterate in CALC, fix up in FIX.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         op_q      <= OP_MUL;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         acc_q     <= '0;
         opnd_q    <= '0;
         cnt_q     <= '0;
         res_q     <= '0;
         result_q  <= '0;
      end else begin
         if (accept) begin
            op_q      <= op_in;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            if (div_in) begin
               acc_q  <= {{XLEN{1'b0}}, abs_a};
               opnd_q <= abs_b;
               cnt_q  <= DIV_LAST;
            end else begin
               acc_q  <= {{XLEN{1'b0}}, abs_b};
               opnd_q <= abs_a;
               cnt_q  <= MUL_LAST;
            end
            if (special)  res_q <= spc_res;
            else if (hit) res_q <= hit_res;
         end else if (state_q == CALC) begin
            acc_q <= op_q[2] ? div_nxt : mul_nxt;
            cnt_q <= cnt_q - CNT_W'(1);
         end else if (state_q == FIX) begin
            res_q <= fix_res;
         end
         if (state_q == DONE && !bus.kill_i) result_q <= res_q;
      end
   end

`ifdef MULDIV_RESULT_CACHE_EN
   logic [XLEN-1:0] a_q, b_q;
   logic            c_vld_q, c_sgn_q;
   logic [XLEN-1:0] c_a_q, c_b_q, c_quo_q, c_rem_q;

   assign hit     = div_in & c_vld_q & (bus.a_i == c_a_q) & (bus.b_i == c_b_q)
                    & (~bus.op_i[0] == c_sgn_q);
   assign hit_res = bus.op_i[1] ? c_rem_q : c_quo_q;

   // Result cache: filled by every divide completion, dropped by kill or a multiply.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_q     <= '0;
         b_q     <= '0;
         c_vld_q <= 1'b0;
         c_sgn_q <= 1'b0;
         c_a_q   <= '0;
         c_b_q   <= '0;
         c_quo_q <= '0;
         c_rem_q <= '0;
      end else if (bus.kill_i) begin
         c_vld_q <= 1'b0;
      end else begin
         if (accept) begin
            a_q <= bus.a_i;
            b_q <= bus.b_i;
         end
         if (accept && special) begin
            c_vld_q <= 1'b1;
            c_sgn_q <= ~bus.op_i[0];
            c_a_q   <= bus.a_i;
            c_b_q   <= bus.b_i;
            c_quo_q <= spc_quo;
            c_rem_q <= spc_rem;
         end else if (state_q == FIX) begin
            if (op_q[2]) begin
               c_vld_q <= 1'b1;
               c_sgn_q <= ~op_q[0];
               c_a_q   <= a_q;
               c_b_q   <= b_q;
               c_quo_q <= quo_f;
               c_rem_q <= rem_f;
            end else begin
               c_vld_q <= 1'b0;
            end
         end
      end
   end
`else
   assign hit     = 1'b0;
   assign hit_res = '0;
`endif

   assign bus.busy_o   = (state_q != IDLE);
   assign bus.valid_o  = (state_q == DONE) && !bus.kill_i;
   assign bus.result_o = bus.valid_o ? res_q : result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a STEP=1 instance and a MUL_STEP=4 /
// DIV_STEP=2 instance share the stimulus wires; sel4 routes start_i.
module tb_muldiv_unit;

   localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
   localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        kill = 1'b0;
   logic        sel4 = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   int          n_chk = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   muldiv_if #(.XLEN(32)) bus ();
   muldiv_if #(.XLEN(32)) bus4 ();

   assign bus.start_i  = start & ~sel4;
   assign bus.op_i     = op;
   assign bus.a_i      = a;
   assign bus.b_i      = b;
   assign bus.kill_i   = kill;
   assign bus4.start_i = start & sel4;
   assign bus4.op_i    = op;
   assign bus4.a_i     = a;
   assign bus4.b_i     = b;
   assign bus4.kill_i  = kill;

   muldiv_unit #(.XLEN(32), .MUL_STEP(1), .DIV_STEP(1)) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   muldiv_unit #(.XLEN(32), .MUL_STEP(4), .DIV_STEP(2)) u_dut4 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus4)
   );

   // Issue one op and wait for valid_o; lat is the cycle count after the start edge.
   task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      #1;
      start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
      lat = 0;
      res = 'x;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (sel4 ? bus4.valid_o : bus.valid_o) begin
            lat = c;
            res = sel4 ? bus4.result_o : bus.result_o;
            break;
         end
      end
      if (lat == 0) begin
         n_chk++; n_err++;
         $display("FAIL timeout op=%0d a=%h b=%h: no valid_o within 100 cycles", o, x, y);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_chk++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
      n_chk++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.valid_o); end
      n_chk++; if (bus.result_o !== 32'h0) begin n_err++; $display("FAIL reset_result got %h want 0", bus.result_o); end
      rst = 1'b0;
   endtask

   task automatic test_mul();
      vec_t tv[6];
      logic [31:0] res;
      int lat;
      tv = '{
         '{"mulh_min",   F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34},
         '{"mul_7xm3",   F_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34},
         '{"mulh_7xm3",  F_MULH,   32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 34},
         '{"mulhsu_m1",  F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34},
         '{"mulhu_max",  F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34},
         '{"mul_6x7",    F_MUL,    32'd6,         32'd7,         32'd42,        34}
      };
      foreach (tv[i]) begin
         do_op(tv[i].op, tv[i].a, tv[i].b, res, lat);
         n_chk++; if (res !== tv[i].exp) begin n_err++; $display("FAIL %s result got %h want %h", tv[i].name, res, tv[i].exp); end
         n_chk++; if (lat !== tv[i].lat) begin n_err++; $display("FAIL %s latency got %0d want %0d", tv[i].name, lat, tv[i].lat); end
      end
   endtask

   task automatic test_div();
      vec_t tv[6];
      logic [31:0] res;
      int lat;
      tv = '{
         '{"div_7_m2",   F_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34},
         '{"div_m7_2",   F_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34},
         '{"divu_f9_2",  F_DIVU, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 34},
         '{"rem_m7_2",   F_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34},
         '{"remu_f9_2",  F_REMU, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 34},
         '{"rem_7_m2",   F_REM,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 34}
      };
      foreach (tv[i]) begin
         do_op(tv[i].op, tv[i].a, tv[i].b, res, lat);
         n_chk++; if (res !== tv[i].exp) begin n_err++; $display("FAIL %s result got %h want %h", tv[i].name, res, tv[i].exp); end
         n_chk++; if (lat !== tv[i].lat) begin n_err++; $display("FAIL %s latency got %0d want %0d", tv[i].name, lat, tv[i].lat); end
      end
   endtask

   task automatic test_special();
      vec_t tv[7];
      logic [31:0] res;
      int lat;
      tv = '{
         '{"div_5_0",     F_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1},
         '{"remu_5_0",    F_REMU, 32'd5,         32'd0,         32'd5,         1},
         '{"divu_5_0",    F_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1},
         '{"rem_5_0",     F_REM,  32'd5,         32'd0,         32'd5,         1},
         '{"div_ovf",     F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
         '{"rem_ovf",     F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1},
         '{"divu_no_ovf", F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         34}
      };
      foreach (tv[i]) begin
         do_op(tv[i].op, tv[i].a, tv[i].b, res, lat);
         n_chk++; if (res !== tv[i].exp) begin n_err++; $display("FAIL %s result got %h want %h", tv[i].name, res, tv[i].exp); end
         n_chk++; if (lat !== tv[i].lat) begin n_err++; $display("FAIL %s latency got %0d want %0d", tv[i].name, lat, tv[i].lat); end
      end
   endtask

   task automatic test_kill();
      int seen;
      int lat;
      logic [31:0] res;
      // kill mid-CALC at cycle 10
      @(negedge clk);
      start = 1'b1; op = F_DIV; a = 32'd100; b = 32'd7;
      @(posedge clk);
      #1 start = 1'b0;
      seen = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (bus.valid_o) seen++;
      end
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      n_chk++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL kill_calc_busy got %b want 0", bus.busy_o); end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.valid_o) seen++;
      end
      n_chk++; if (seen !== 0) begin n_err++; $display("FAIL kill_calc_valid got %0d pulses want 0", seen); end
      do_op(F_MUL, 32'd6, 32'd7, res, lat);
      n_chk++; if (res !== 32'd42) begin n_err++; $display("FAIL kill_then_mul result got %h want 2a", res); end
      n_chk++; if (lat !== 34) begin n_err++; $display("FAIL kill_then_mul latency got %0d want 34", lat); end
      // kill together with start in IDLE
      @(negedge clk);
      start = 1'b1; kill = 1'b1; op = F_MUL; a = 32'd2; b = 32'd3;
      @(posedge clk);
      #1 start = 1'b0; kill = 1'b0;
      @(negedge clk);
      n_chk++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL kill_start_busy got %b want 0", bus.busy_o); end
      // kill in DONE suppresses valid_o and leaves result_o alone
      @(negedge clk);
      start = 1'b1; op = F_MUL; a = 32'd3; b = 32'd5;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 33; c++) @(negedge clk);
      @(negedge clk);
      kill = 1'b1;
      #1;
      n_chk++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL kill_done_valid got %b want 0", bus.valid_o); end
      n_chk++; if (bus.result_o !== 32'd42) begin n_err++; $display("FAIL kill_done_result got %h want 2a", bus.result_o); end
      @(negedge clk);
      kill = 1'b0;
      n_chk++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL kill_done_busy got %b want 0", bus.busy_o); end
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [31:0] res;
      @(negedge clk);
      start = 1'b1; op = F_MUL; a = 32'd9; b = 32'd9;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_chk++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %b want 0", bus.busy_o); end
      n_chk++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid got %b want 0", bus.valid_o); end
      n_chk++; if (bus.result_o !== 32'h0) begin n_err++; $display("FAIL rst_mid_result got %h want 0", bus.result_o); end
      do_op(F_DIVU, 32'd100, 32'd7, res, lat);
      n_chk++; if (res !== 32'd14) begin n_err++; $display("FAIL rst_then_divu result got %h want e", res); end
      n_chk++; if (lat !== 34) begin n_err++; $display("FAIL rst_then_divu latency got %0d want 34", lat); end
   endtask

   task automatic test_back_to_back();
      int first, second, pulses;
      logic [31:0] r1, r2;
      first = 0; second = 0; pulses = 0; r1 = '0; r2 = '0;
      @(negedge clk);
      start = 1'b1; op = F_MUL; a = 32'd3; b = 32'd5;
      @(posedge clk);
      #1;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (bus.valid_o) begin
            pulses++;
            if (first == 0) begin
               first = c; r1 = bus.result_o;
            end else begin
               second = c; r2 = bus.result_o; start = 1'b0;
               break;
            end
         end
      end
      start = 1'b0;
      @(negedge clk);
      n_chk++; if (first !== 34) begin n_err++; $display("FAIL b2b_first_cycle got %0d want 34", first); end
      n_chk++; if (second !== 69) begin n_err++; $display("FAIL b2b_second_cycle got %0d want 69", second); end
      n_chk++; if (r1 !== 32'd15 || r2 !== 32'd15) begin n_err++; $display("FAIL b2b_results got %h,%h want f,f", r1, r2); end
      n_chk++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL b2b_idle_busy got %b want 0", bus.busy_o); end
   endtask

   task automatic test_step4();
      vec_t tv[4];
      logic [31:0] res;
      int lat;
      tv = '{
         '{"s4_mul_6x7",  F_MUL,  32'd6,         32'd7,         32'd42,        10},
         '{"s4_mulh_min", F_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 10},
         '{"s2_div_m7_2", F_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 18},
         '{"s2_rem_100_7",F_REM,  32'd100,       32'd7,         32'd2,         18}
      };
      sel4 = 1'b1;
      foreach (tv[i]) begin
         do_op(tv[i].op, tv[i].a, tv[i].b, res, lat);
         n_chk++; if (res !== tv[i].exp) begin n_err++; $display("FAIL %s result got %h want %h", tv[i].name, res, tv[i].exp); end
         n_chk++; if (lat !== tv[i].lat) begin n_err++; $display("FAIL %s latency got %0d want %0d", tv[i].name, lat, tv[i].lat); end
      end
      sel4 = 1'b0;
   endtask

   task automatic test_cache();
      logic [31:0] res;
      int lat;
      do_op(F_DIV, 32'd100, 32'd7, res, lat);
      n_chk++; if (res !== 32'd14) begin n_err++; $display("FAIL cache_div result got %h want e", res); end
      n_chk++; if (lat !== 34) begin n_err++; $display("FAIL cache_div latency got %0d want 34", lat); end
      do_op(F_REM, 32'd100, 32'd7, res, lat);
      n_chk++; if (res !== 32'd2) begin n_err++; $display("FAIL cache_rem result got %h want 2", res); end
`ifdef MULDIV_RESULT_CACHE_EN
      n_chk++; if (lat !== 1) begin n_err++; $display("FAIL cache_rem_hit latency got %0d want 1", lat); end
      @(negedge clk); kill = 1'b1;
      @(negedge clk); kill = 1'b0;
      do_op(F_REM, 32'd100, 32'd7, res, lat);
      n_chk++; if (res !== 32'd2) begin n_err++; $display("FAIL cache_killed_rem result got %h want 2", res); end
      n_chk++; if (lat !== 34) begin n_err++; $display("FAIL cache_killed_rem latency got %0d want 34", lat); end
      do_op(F_MUL, 32'd6, 32'd7, res, lat);
      do_op(F_DIV, 32'd100, 32'd7, res, lat);
      n_chk++; if (lat !== 34) begin n_err++; $display("FAIL cache_after_mul latency got %0d want 34", lat); end
`else
      n_chk++; if (lat !== 34) begin n_err++; $display("FAIL nocache_rem latency got %0d want 34", lat); end
`endif
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_kill();
      test_reset_mid();
      test_back_to_back();
      test_step4();
      test_cache();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
